conv_buf_loader: RTL
====================

# conv_buf_loader

Write-side feeder for one convolution unit's weight and feature-map buffers. It takes load commands and a 64-bit beat stream from the DDR reader and steers each beat into either the weight-buffer or the feature-map-buffer write port. It paces transfers in unit bursts so that a transfer never starts while the target buffer reports full. It sits between the DDR read engine and the `wb_*` / `fb_*` / `di` inputs of a conv unit.

## Interface
- `DATA_WIDTH`, 64, beat width.
- `UNIT_BURSTS_WEI`, 32, beats per weight unit burst; power of 2.
- `UNIT_BURSTS_FTM`, 1024, beats per feature-map unit burst; power of 2.
- `B_LEN`, 24, width of beat-count fields.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_sel`  in  1  target: 0 = weight buffer, 1 = feature-map buffer.
- `cmd_clr`  in  1  clear the target buffer before loading.
- `cmd_len`  in  B_LEN  total beats.
- `cmd_cfg`  in  32  shape word for the target buffer.
- `s_valid`  in  1  stream beat valid.
- `s_ready`  out  1  stream beat accepted when `s_valid & s_ready`.
- `s_data`  in  DATA_WIDTH  stream beat.
- `wb_we`, `fb_we`  out  1  buffer write strobes.
- `wb_clr`, `fb_clr`  out  1  buffer clear pulses.
- `wb_cfg`, `fb_cfg`  out  32  registered shape words.
- `wb_full`, `fb_full`  in  1  high = fewer than one unit burst free.
- `di`  out  DATA_WIDTH  write data shared by both buffers.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the last beat of a command is written.
- `err`  out  1  one-cycle pulse when a command is rejected.

## Operation
- States: IDLE, CLR, CHECK, STREAM, DONE.
- `UNIT` = `UNIT_BURSTS_WEI` if `sel` = 0, else `UNIT_BURSTS_FTM`.

IDLE:
- `cmd_ready` = 1.
- On accept, latch `sel`, `len`, `clr`.
- Reject the command if `cmd_len` = 0 or `cmd_len[log2(UNIT)-1:0]` ≠ 0: pulse `err` next cycle, stay in IDLE, leave cfg outputs unchanged.
- Otherwise load `cmd_cfg` into `wb_cfg` or `fb_cfg` (the other cfg output holds) and go to CLR if `clr`, else CHECK.

CLR:
- Pulse the selected `*_clr` for exactly 1 cycle, then go to CHECK.

CHECK:
- Settle counter forces at least 2 cycles in this state, so the final registered write of the previous unit has updated the buffer pointers.
- After that, move to STREAM in the first cycle in which the selected `*_full` = 0.
- Stay in CHECK indefinitely while full is high.

STREAM:
- `s_ready` = 1.
- Every handshake decrements the unit-beat counter (loaded with `UNIT`) and `remaining`.
- A stall (`s_valid` = 0) holds all state.
- When the unit counter reaches 0: go to DONE if `remaining` = 0, else CHECK.
- `full` is ignored inside a unit burst.

DONE:
- `done` = 1 for 1 cycle, then go to IDLE.

Write path:
- `di <= s_data`, `*_we <= s_valid & s_ready` for the selected buffer only.
- Both write strobes never assert in the same cycle.
- `di` holds its last value when no write occurs.

## Timing
- Reset (async, asynchronous assertion) forces:
  - state IDLE;
  - `cmd_ready` = 1;
  - `s_ready` = 0;
  - `wb_we` = `fb_we` = 0, `wb_clr` = `fb_clr` = 0;
  - `wb_cfg` = `fb_cfg` = 0, `di` = 0;
  - `busy` = `done` = `err` = 0.
- Reset mid-stream drops the in-flight command; no partial-unit recovery.
- `s_ready` and `cmd_ready` are combinational decodes of registered state only; they do not depend on same-cycle `s_valid` or `full`.
- Write latency: beat accepted in cycle t → `*_we` = 1 and `di` = beat in cycle t+1.
- `done` is asserted in the same cycle as the last `*_we`.
- Command accept to first `s_ready` (`clr` = 0, `full` = 0) = 3 cycles; add 1 with `clr` = 1.
- Gap between units (`full` = 0) = 2 cycles of `s_ready` = 0.
- Counter width `B_LEN`; `cmd_len` up to 2^B_LEN − UNIT with no wrap.
- A command cannot be accepted while `busy` = 1.

## Test plan
- Weight load: `sel`=0, `clr`=1, `len`=64, `full`=0, continuous `s_valid` → 1 `wb_clr` pulse, then two 32-beat `wb_we` runs separated by 2 idle cycles. `di` sequence must equal the input sequence, `fb_we` never asserts, `done` is asserted with the 64th `wb_we`.
- Backpressure: `sel`=1, `len`=2048, `fb_full` forced high after the first unit for 50 cycles → `s_ready` = 0 throughout; streaming resumes exactly 1 cycle after `fb_full` falls; exactly 2048 `fb_we` in total.
- Stream stalls: random `s_valid` at 50% duty, `len`=32 → exactly 32 writes in order, with no duplicates or drops.
- Rejected commands: `len`=0, then `sel`=0 `len`=33 → `err` pulses twice, `busy` stays 0, `wb_cfg` unchanged, no write or clear strobes.
- Async reset: assert `rstn`=0 mid-unit → all outputs return to their reset values without waiting for a clock edge; a new command after release runs normally.
- Cfg isolation: weight command with `cfg`=0x1234, then feature-map command with `cfg`=0xABCD → `wb_cfg` stays 0x1234 and `fb_cfg` = 0xABCD.

Source files
------------

// File: rtl/conv_buf_loader.sv
// Write-side feeder for a conv unit's weight / feature-map buffers.
// Steers a 64-bit beat stream into one buffer in full-gated unit bursts.
module conv_buf_loader #(
    parameter int DATA_WIDTH      = 64,
    parameter int UNIT_BURSTS_WEI = 32,
    parameter int UNIT_BURSTS_FTM = 1024,
    parameter int B_LEN           = 24
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_sel,
    input  logic                  cmd_clr,
    input  logic [B_LEN-1:0]      cmd_len,
    input  logic [31:0]           cmd_cfg,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  wb_we,
    output logic                  fb_we,
    output logic                  wb_clr,
    output logic                  fb_clr,
    output logic [31:0]           wb_cfg,
    output logic [31:0]           fb_cfg,
    input  logic                  wb_full,
    input  logic                  fb_full,
    output logic [DATA_WIDTH-1:0] di,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int UMAX = (UNIT_BURSTS_FTM > UNIT_BURSTS_WEI) ? UNIT_BURSTS_FTM : UNIT_BURSTS_WEI;
    localparam int UW   = $clog2(UMAX) + 1;

    localparam logic [B_LEN-1:0] MASK_WEI = B_LEN'(UNIT_BURSTS_WEI - 1);
    localparam logic [B_LEN-1:0] MASK_FTM = B_LEN'(UNIT_BURSTS_FTM - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            r_state;
    logic                  r_sel;
    logic [B_LEN-1:0]      r_rem;
    logic [UW-1:0]         r_unit;
    logic                  r_settle;
    logic [DATA_WIDTH-1:0] r_di;
    logic                  r_wb_we;
    logic                  r_fb_we;
    logic [31:0]           r_wb_cfg;
    logic [31:0]           r_fb_cfg;
    logic                  r_err;

    logic                  w_s_ready;
    logic                  w_hs;
    logic [B_LEN-1:0]      w_mask;
    logic                  w_reject;
    logic                  w_full;
    logic [UW-1:0]         w_unit_load;

    assign w_s_ready   = (r_state == S_STREAM);
    assign w_hs        = s_valid & w_s_ready;
    assign w_mask      = cmd_sel ? MASK_FTM : MASK_WEI;
    assign w_reject    = (cmd_len == '0) | ((cmd_len & w_mask) != '0);
    assign w_full      = r_sel ? fb_full : wb_full;
    assign w_unit_load = r_sel ? UW'(UNIT_BURSTS_FTM) : UW'(UNIT_BURSTS_WEI);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_sel    <= 1'b0;
            r_rem    <= '0;
            r_unit   <= '0;
            r_settle <= 1'b0;
            r_di     <= '0;
            r_wb_we  <= 1'b0;
            r_fb_we  <= 1'b0;
            r_wb_cfg <= '0;
            r_fb_cfg <= '0;
            r_err    <= 1'b0;
        end else begin
            r_wb_we <= w_hs & ~r_sel;
            r_fb_we <= w_hs & r_sel;
            if (w_hs) r_di <= s_data;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_sel    <= cmd_sel;
                            r_rem    <= cmd_len;
                            r_settle <= 1'b0;
                            if (cmd_sel) r_fb_cfg <= cmd_cfg;
                            else         r_wb_cfg <= cmd_cfg;
                            r_state  <= cmd_clr ? S_CLR : S_CHECK;
                        end
                    end
                end
                S_CLR: r_state <= S_CHECK;
                // First CHECK cycle only arms the settle flag so the last
                // registered write of the previous unit reaches the buffer.
                S_CHECK: begin
                    if (!r_settle) begin
                        r_settle <= 1'b1;
                    end else if (!w_full) begin
                        r_unit  <= w_unit_load;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_unit <= r_unit - UW'(1);
                        r_rem  <= r_rem - B_LEN'(1);
                        if (r_unit == UW'(1)) begin
                            r_settle <= 1'b0;
                            r_state  <= (r_rem == B_LEN'(1)) ? S_DONE : S_CHECK;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign s_ready   = w_s_ready;
    assign wb_clr    = (r_state == S_CLR) & ~r_sel;
    assign fb_clr    = (r_state == S_CLR) & r_sel;
    assign wb_we     = r_wb_we;
    assign fb_we     = r_fb_we;
    assign wb_cfg    = r_wb_cfg;
    assign fb_cfg    = r_fb_cfg;
    assign di        = r_di;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

endmodule
